// File: rtl/hamming_class_search.sv
// hamming_class_search: Hamming-distance associative search over streamed class hypervectors.
// Optional MARGIN_OUT_EN adds second-smallest distance and best-vs-second margin outputs.
module hamming_class_search #(
  parameter int DHV_SIZE = 4000,
  parameter int CLASS_W  = 6,
  parameter int DIST_W   = 12
) (
  input  logic                clk,
  input  logic                reset_in,
  input  logic                query_valid,
  input  logic [DHV_SIZE-1:0] query_hv,
  input  logic                class_valid,
  input  logic [DHV_SIZE-1:0] class_hv,
  input  logic [CLASS_W-1:0]  class_idx,
  input  logic                class_last,
`ifdef MARGIN_OUT_EN
  output logic [DIST_W-1:0]   second_dist,
  output logic [DIST_W-1:0]   margin,
`endif
  output logic                busy,
  output logic                result_valid,
  output logic [CLASS_W-1:0]  best_class,
  output logic [DIST_W-1:0]   best_dist
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DHV_SIZE-1:0] query_q, query_d;
  logic                drain_q, drain_d;
  logic                s1_valid_q, s1_valid_d;
  logic [DIST_W-1:0]   s1_dist_q, s1_dist_d;
  logic [CLASS_W-1:0]  s1_idx_q, s1_idx_d;
  logic [DIST_W-1:0]   min_dist_q, min_dist_d;
  logic [CLASS_W-1:0]  min_idx_q, min_idx_d;
  logic                result_valid_q, result_valid_d;
  logic [CLASS_W-1:0]  best_class_q, best_class_d;
  logic [DIST_W-1:0]   best_dist_q, best_dist_d;
`ifdef MARGIN_OUT_EN
  logic [DIST_W-1:0]   sec_dist_q, sec_dist_d;
  logic [DIST_W-1:0]   second_dist_q, second_dist_d;
  logic [DIST_W-1:0]   margin_q, margin_d;
`endif

  function automatic logic [DIST_W-1:0] popcount(
    input logic [DHV_SIZE-1:0] v
  );
    logic [DIST_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DHV_SIZE; i++) begin
      cnt = cnt + DIST_W'(v[i]);
    end
    return cnt;
  endfunction

  // Next-state: FSM, S1 distance stage, S2 running-min stage, result capture
  always_comb begin
    state_d        = state_q;
    query_d        = query_q;
    drain_d        = drain_q;
    s1_valid_d     = 1'b0;
    s1_dist_d      = s1_dist_q;
    s1_idx_d       = s1_idx_q;
    min_dist_d     = min_dist_q;
    min_idx_d      = min_idx_q;
    result_valid_d = 1'b0;
    best_class_d   = best_class_q;
    best_dist_d    = best_dist_q;
`ifdef MARGIN_OUT_EN
    sec_dist_d     = sec_dist_q;
    second_dist_d  = second_dist_q;
    margin_d       = margin_q;
`endif

    // strict compare keeps the earlier class on ties
    if (s1_valid_q) begin
      if (s1_dist_q < min_dist_q) begin
        min_dist_d = s1_dist_q;
        min_idx_d  = s1_idx_q;
`ifdef MARGIN_OUT_EN
        sec_dist_d = min_dist_q;
      end else if (s1_dist_q < sec_dist_q) begin
        sec_dist_d = s1_dist_q;
`endif
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (query_valid) begin
          state_d    = S_SEARCH;
          query_d    = query_hv;
          min_dist_d = '1;
          min_idx_d  = '0;
`ifdef MARGIN_OUT_EN
          sec_dist_d = '1;
`endif
        end
      end
      S_SEARCH: begin
        if (class_valid) begin
          s1_valid_d = 1'b1;
          s1_dist_d  = popcount(query_q ^ class_hv);
          s1_idx_d   = class_idx;
          if (class_last) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d        = S_IDLE;
        result_valid_d = 1'b1;
        best_class_d   = min_idx_q;
        best_dist_d    = min_dist_q;
`ifdef MARGIN_OUT_EN
        second_dist_d  = sec_dist_q;
        margin_d       = sec_dist_q - min_dist_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q        <= S_IDLE;
      query_q        <= '0;
      drain_q        <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_dist_q      <= '0;
      s1_idx_q       <= '0;
      min_dist_q     <= '0;
      min_idx_q      <= '0;
      result_valid_q <= 1'b0;
      best_class_q   <= '0;
      best_dist_q    <= '0;
`ifdef MARGIN_OUT_EN
      sec_dist_q     <= '0;
      second_dist_q  <= '0;
      margin_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      query_q        <= query_d;
      drain_q        <= drain_d;
      s1_valid_q     <= s1_valid_d;
      s1_dist_q      <= s1_dist_d;
      s1_idx_q       <= s1_idx_d;
      min_dist_q     <= min_dist_d;
      min_idx_q      <= min_idx_d;
      result_valid_q <= result_valid_d;
      best_class_q   <= best_class_d;
      best_dist_q    <= best_dist_d;
`ifdef MARGIN_OUT_EN
      sec_dist_q     <= sec_dist_d;
      second_dist_q  <= second_dist_d;
      margin_q       <= margin_d;
`endif
    end
  end

  assign busy         = (state_q == S_SEARCH) || (state_q == S_DRAIN);
  assign result_valid = result_valid_q;
  assign best_class   = best_class_q;
  assign best_dist    = best_dist_q;
`ifdef MARGIN_OUT_EN
  assign second_dist  = second_dist_q;
  assign margin       = margin_q;
`endif

endmodule

// File: tb/tb_hamming_class_search.sv
// tb_hamming_class_search: table, hand-written and random checks of hamming_class_search.
// Margin outputs are checked when MARGIN_OUT_EN is defined.
module tb_hamming_class_search;

  localparam int DHV = 16;
  localparam int CW  = 6;
  localparam int DW  = 5;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          query_valid = 1'b0;
  logic [DHV-1:0] query_hv = '0;
  logic          class_valid = 1'b0;
  logic [DHV-1:0] class_hv = '0;
  logic [CW-1:0] class_idx = '0;
  logic          class_last = 1'b0;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] best_class;
  logic [DW-1:0] best_dist;
`ifdef MARGIN_OUT_EN
  logic [DW-1:0] second_dist;
  logic [DW-1:0] margin;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [DHV-1:0] hv_q[$];
  int             idx_q[$];
  bit             gaps = 0;

  hamming_class_search #(
    .DHV_SIZE(DHV),
    .CLASS_W(CW),
    .DIST_W(DW)
  ) dut (
    .clk(clk),
    .reset_in(reset_in),
    .query_valid(query_valid),
    .query_hv(query_hv),
    .class_valid(class_valid),
    .class_hv(class_hv),
    .class_idx(class_idx),
    .class_last(class_last),
`ifdef MARGIN_OUT_EN
    .second_dist(second_dist),
    .margin(margin),
`endif
    .busy(busy),
    .result_valid(result_valid),
    .best_class(best_class),
    .best_dist(best_dist)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // reference: min distance, earliest index on ties, second smallest
  task automatic model(input logic [DHV-1:0] q, output int bc,
                       output int bd, output int sd);
    int d[$];
    bd = 99;
    bc = 0;
    foreach (hv_q[i]) begin
      d.push_back($countones(q ^ hv_q[i]));
      if (d[i] < bd) begin
        bd = d[i];
        bc = idx_q[i];
      end
    end
    d.sort();
    sd = (d.size() > 1) ? d[1] : (1 << DW) - 1;
  endtask

  task automatic send_query(input logic [DHV-1:0] q);
    query_valid = 1'b1;
    query_hv = q;
    @(posedge clk); #1;
    query_valid = 1'b0;
    query_hv = '0;
  endtask

  task automatic beat(input logic [DHV-1:0] hv, input int idx,
                      input bit last);
    class_valid = 1'b1;
    class_hv = hv;
    class_idx = CW'(idx);
    class_last = last;
    @(posedge clk); #1;
    class_valid = 1'b0;
    class_last = 1'b0;
  endtask

  task automatic wait_result(input string name, input int ecls,
                             input int edist, input int esec);
    int cyc = 0;
    bit seen = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        seen = 1;
        cyc = c;
      end
    end
    check({name, " latency"}, cyc, 3);
    if (seen) begin
      check({name, " class"}, int'(best_class), ecls);
      check({name, " dist"}, int'(best_dist), edist);
      check({name, " busy_at_result"}, int'(busy), 0);
`ifdef MARGIN_OUT_EN
      check({name, " second"}, int'(second_dist), esec);
      check({name, " margin"}, int'(margin), (esec - edist) & ((1 << DW) - 1));
`else
      if (esec < 0) $display("unexpected second %0d", esec);
`endif
      @(posedge clk); #1;
      check({name, " pulse_width"}, int'(result_valid), 0);
    end
  endtask

  task automatic run_query(input logic [DHV-1:0] q, input string name);
    int bc, bd, sd;
    model(q, bc, bd, sd);
    send_query(q);
    foreach (hv_q[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        class_last = $urandom_range(0, 1) == 1;
        class_hv = DHV'($urandom);
        @(posedge clk); #1;
        class_last = 1'b0;
      end
      beat(hv_q[i], idx_q[i], i == hv_q.size() - 1);
    end
    wait_result(name, bc, bd, sd);
  endtask

  typedef struct {
    logic [DHV-1:0] q;
    int             n;
    logic [DHV-1:0] hv[4];
    int             idx[4];
    int             ecls;
    int             edist;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{16'h00FF, 3, '{16'hFFFF, 16'h00F0, 16'hFF00, 16'h0},
               '{0, 1, 2, 0}, 1, 4};
    tbl[1] = '{16'h0000, 2, '{16'h0003, 16'h0300, 16'h0, 16'h0},
               '{0, 1, 0, 0}, 0, 2};
    tbl[2] = '{16'hAAAA, 1, '{16'h5555, 16'h0, 16'h0, 16'h0},
               '{5, 0, 0, 0}, 5, 16};
    tbl[3] = '{16'h1234, 3, '{16'h1235, 16'h1234, 16'h1230, 16'h0},
               '{7, 9, 2, 0}, 9, 0};
    tbl[4] = '{16'h0000, 2, '{16'hFFFF, 16'hFFFF, 16'h0, 16'h0},
               '{3, 4, 0, 0}, 3, 16};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset result_valid", int'(result_valid), 0);
    check("reset best_class", int'(best_class), 0);
    check("reset best_dist", int'(best_dist), 0);
    reset_in = 1'b0;
    @(posedge clk); #1;

    // table vectors
    for (int t = 0; t < 5; t++) begin
      hv_q.delete();
      idx_q.delete();
      for (int i = 0; i < tbl[t].n; i++) begin
        hv_q.push_back(tbl[t].hv[i]);
        idx_q.push_back(tbl[t].idx[i]);
      end
      run_query(tbl[t].q, $sformatf("tbl%0d", t));
      check($sformatf("tbl%0d const class", t), int'(best_class), tbl[t].ecls);
      check($sformatf("tbl%0d const dist", t), int'(best_dist), tbl[t].edist);
    end

    // protocol: stray class beat in IDLE, second query during SEARCH
    beat(16'h00FF, 9, 1'b1);
    check("idle beat no busy", int'(busy), 0);
    send_query(16'h00FF);
    check("busy after query", int'(busy), 1);
    query_valid = 1'b1;
    query_hv = 16'hFFFF;
    beat(16'hFFFF, 0, 1'b0);
    query_valid = 1'b0;
    class_last = 1'b1;
    @(posedge clk); #1;
    class_last = 1'b0;
    check("busy in search", int'(busy), 1);
    beat(16'h00F0, 1, 1'b0);
    beat(16'hFF00, 2, 1'b1);
    @(posedge clk); #1;
    check("busy in drain", int'(busy), 1);
    @(posedge clk); #1;
    check("busy low at done", int'(busy), 0);
    @(posedge clk); #1;
    check("proto result_valid", int'(result_valid), 1);
    check("proto class", int'(best_class), 1);
    check("proto dist", int'(best_dist), 4);

    // reset during drain
    send_query(16'h00FF);
    beat(16'hFFFF, 0, 1'b0);
    beat(16'h00F0, 1, 1'b0);
    beat(16'hFF00, 2, 1'b1);
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    check("rst busy", int'(busy), 0);
    check("rst best_class", int'(best_class), 0);
    check("rst best_dist", int'(best_dist), 0);
    begin
      int pulses = 0;
      for (int c = 0; c < 6; c++) begin
        if (result_valid) pulses++;
        @(posedge clk); #1;
      end
      check("rst no pulse", pulses, 0);
    end
    hv_q = '{16'hFFFF, 16'h00F0, 16'hFF00};
    idx_q = '{0, 1, 2};
    run_query(16'h00FF, "after_rst");

    // back-to-back 32 beats, idx 17 exact match
    begin
      logic [DHV-1:0] q;
      q = 16'hC3A5;
      hv_q.delete();
      idx_q.delete();
      for (int k = 0; k < 32; k++) begin
        int d;
        logic [31:0] m;
        d = (k == 17) ? 0 : 1 + (k % 16);
        m = (32'h1 << d) - 32'h1;
        hv_q.push_back(q ^ m[DHV-1:0]);
        idx_q.push_back(k);
      end
      run_query(q, "b2b");
      check("b2b const class", int'(best_class), 17);
      check("b2b const dist", int'(best_dist), 0);
    end

    // randomized queries with optional gaps
    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(1, 8);
      gaps = r >= 20;
      hv_q.delete();
      idx_q.delete();
      for (int i = 0; i < n; i++) begin
        hv_q.push_back(DHV'($urandom));
        idx_q.push_back($urandom_range(0, (1 << CW) - 1));
      end
      run_query(DHV'($urandom), $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
